// File: rtl/frame_pkg.sv
// Shared definitions for the multi-channel frame policer: per-channel state
// encoding, o_err bit positions and the channel-id width helper.
package frame_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_INFRAME = 2'd1;
  localparam logic [1:0] ST_TRUNC   = 2'd2;

  typedef enum logic [1:0] {
    FS_IDLE    = ST_IDLE,
    FS_INFRAME = ST_INFRAME,
    FS_TRUNC   = ST_TRUNC
  } frame_state_e;

  localparam int ERR_SPUR   = 0;
  localparam int ERR_ORPHAN = 1;
  localparam int ERR_TRUNC  = 2;
  localparam int ERR_BADCH  = 3;

  function automatic int chWidth(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/frame_ch_tracker.sv
// Framing state and beat count for a single channel. Outputs describe how the
// current beat would be treated; state only moves when i_en is high.
//
//  state      | meaning
//  ST_IDLE    | no open frame; non-SOP beats are orphans
//  ST_INFRAME | frame open, len beats already forwarded
//  ST_TRUNC   | frame was cut at MAX_LEN; silently discard until EOP or new SOP
module frame_ch_tracker
  import frame_pkg::*;
#(
  parameter int MAX_LEN     = 256,
  parameter bit DROP_ORPHAN = 1'b1
) (
  input  logic i_clk,
  input  logic i_srst_n,
  input  logic i_en,
  input  logic i_sop,
  input  logic i_eop,
  output logic o_fwd,
  output logic o_sop,
  output logic o_eop,
  output logic o_err_trunc,
  output logic o_err_orphan,
  output logic o_err_spur
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(MAX_LEN - 1);

  logic [1:0]       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    o_fwd        = 1'b0;
    o_sop        = 1'b0;
    o_eop        = 1'b0;
    o_err_trunc  = 1'b0;
    o_err_orphan = 1'b0;
    o_err_spur   = 1'b0;
    if (state_q == ST_INFRAME) begin
      o_fwd      = 1'b1;
      o_err_spur = i_sop;
      if (i_eop) begin
        o_eop   = 1'b1;
        state_d = ST_IDLE;
        len_d   = '0;
      end else if (len_q == LEN_LAST) begin
        o_eop       = 1'b1;
        o_err_trunc = 1'b1;
        state_d     = ST_TRUNC;
        len_d       = '0;
      end else begin
        len_d = len_q + 1'b1;
      end
    end else if (i_sop) begin
      // A SOP opens a new frame from both IDLE and TRUNC
      o_fwd   = 1'b1;
      o_sop   = 1'b1;
      o_eop   = i_eop;
      state_d = i_eop ? ST_IDLE : ST_INFRAME;
      len_d   = i_eop ? '0 : LEN_W'(1);
    end else if (state_q == ST_TRUNC) begin
      if (i_eop) state_d = ST_IDLE;
    end else begin
      o_err_orphan = 1'b1;
      o_fwd        = !DROP_ORPHAN;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_srst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
    end else if (i_en) begin
      state_q <= state_d;
      len_q   <= len_d;
    end
  end

endmodule

// File: rtl/frame_mc_policer.sv
// Multi-channel framing corrector and policer: one tracker per channel, the
// addressed channel's verdict is muxed and registered (1-cycle latency).
module frame_mc_policer
  import frame_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 32,
  parameter int MAX_LEN     = 256,
  parameter bit DROP_ORPHAN = 1'b1,
  parameter int CNT_W       = 16,
  localparam int CH_W       = chWidth(NUM_CH)
) (
  input  logic              i_clk,
  input  logic              i_srst_n,
  input  logic              i_valid,
  input  logic              i_sop,
  input  logic              i_eop,
  input  logic [CH_W-1:0]   i_ch,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic              o_sop,
  output logic              o_eop,
  output logic [CH_W-1:0]   o_ch,
  output logic [DATA_W-1:0] o_data,
  output logic [3:0]        o_err,
  output logic [CNT_W-1:0]  o_errCnt
);

  logic [NUM_CH-1:0] en, fwd, t_sop, t_eop, t_trunc, t_orphan, t_spur;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign en[c] = i_valid && (i_ch == CH_W'(c));

    frame_ch_tracker #(
      .MAX_LEN    (MAX_LEN),
      .DROP_ORPHAN(DROP_ORPHAN)
    ) u_trk (
      .i_clk       (i_clk),
      .i_srst_n    (i_srst_n),
      .i_en        (en[c]),
      .i_sop       (i_sop),
      .i_eop       (i_eop),
      .o_fwd       (fwd[c]),
      .o_sop       (t_sop[c]),
      .o_eop       (t_eop[c]),
      .o_err_trunc (t_trunc[c]),
      .o_err_orphan(t_orphan[c]),
      .o_err_spur  (t_spur[c])
    );
  end

  logic ch_ok, sel_fwd, sel_sop, sel_eop, sel_trunc, sel_orphan, sel_spur;

  // Channel ids at or above NUM_CH match no tracker and leave ch_ok low
  always_comb begin
    ch_ok      = 1'b0;
    sel_fwd    = 1'b0;
    sel_sop    = 1'b0;
    sel_eop    = 1'b0;
    sel_trunc  = 1'b0;
    sel_orphan = 1'b0;
    sel_spur   = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (i_ch == CH_W'(c)) begin
        ch_ok      = 1'b1;
        sel_fwd    = fwd[c];
        sel_sop    = t_sop[c];
        sel_eop    = t_eop[c];
        sel_trunc  = t_trunc[c];
        sel_orphan = t_orphan[c];
        sel_spur   = t_spur[c];
      end
    end
  end

  logic              valid_q, valid_d;
  logic              sop_q, sop_d;
  logic              eop_q, eop_d;
  logic [CH_W-1:0]   ch_q;
  logic [DATA_W-1:0] data_q;
  logic [3:0]        err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    valid_d           = i_valid && ch_ok && sel_fwd;
    sop_d             = valid_d && sel_sop;
    eop_d             = valid_d && sel_eop;
    err_d             = '0;
    err_d[ERR_BADCH]  = i_valid && !ch_ok;
    err_d[ERR_TRUNC]  = i_valid && ch_ok && sel_trunc;
    err_d[ERR_ORPHAN] = i_valid && ch_ok && sel_orphan;
    err_d[ERR_SPUR]   = i_valid && ch_ok && sel_spur;
    cnt_d             = cnt_q;
    if ((|err_d) && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_srst_n) begin
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      ch_q    <= '0;
      data_q  <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      ch_q    <= i_ch;
      data_q  <= i_data;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_valid  = valid_q;
  assign o_sop    = sop_q;
  assign o_eop    = eop_q;
  assign o_ch     = ch_q;
  assign o_data   = data_q;
  assign o_err    = err_q;
  assign o_errCnt = cnt_q;

endmodule

// File: tb/tb_frame_mc_policer.sv
// Bench for frame_mc_policer: directed scenarios followed by random interleaved
// traffic, all checked against a per-channel frame model.
module tb_frame_mc_policer;

  localparam int NCH  = 3;
  localparam int DW   = 8;
  localparam int ML   = 4;
  localparam bit DROP = 1'b1;
  localparam int CW   = 5;
  localparam int CHW  = 2;

  logic           clk = 1'b0;
  logic           i_srst_n, i_valid, i_sop, i_eop;
  logic [CHW-1:0] i_ch;
  logic [DW-1:0]  i_data;
  logic           o_valid, o_sop, o_eop;
  logic [CHW-1:0] o_ch;
  logic [DW-1:0]  o_data;
  logic [3:0]     o_err;
  logic [CW-1:0]  o_errCnt;

  always #5 clk = ~clk;

  frame_mc_policer #(
    .NUM_CH     (NCH),
    .DATA_W     (DW),
    .MAX_LEN    (ML),
    .DROP_ORPHAN(DROP),
    .CNT_W      (CW)
  ) dut (
    .i_clk   (clk),
    .i_srst_n(i_srst_n),
    .i_valid (i_valid),
    .i_sop   (i_sop),
    .i_eop   (i_eop),
    .i_ch    (i_ch),
    .i_data  (i_data),
    .o_valid (o_valid),
    .o_sop   (o_sop),
    .o_eop   (o_eop),
    .o_ch    (o_ch),
    .o_data  (o_data),
    .o_err   (o_err),
    .o_errCnt(o_errCnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame model: open flag, beats already in the frame, and discard-after-cut flag
  bit open_m [NCH];
  bit drop_m [NCH];
  int beats_m[NCH];
  int cnt_m;

  logic           e_valid, e_sop, e_eop;
  logic [CHW-1:0] e_ch;
  logic [DW-1:0]  e_data;
  logic [3:0]     e_err;

  task automatic model(input bit rst_n, input bit v, input bit s, input bit e,
                       input int ch, input logic [DW-1:0] d);
    e_valid = 0; e_sop = 0; e_eop = 0; e_err = 0;
    e_ch = CHW'(ch); e_data = d;
    if (!rst_n) begin
      e_ch = 0; e_data = 0; cnt_m = 0;
      for (int c = 0; c < NCH; c++) begin
        open_m[c] = 0; drop_m[c] = 0; beats_m[c] = 0;
      end
      return;
    end
    if (v) begin
      if (ch >= NCH) begin
        e_err = 4'b1000;
      end else if (open_m[ch]) begin
        e_valid = 1;
        if (s) e_err[0] = 1;
        if (e) begin
          e_eop = 1; open_m[ch] = 0;
        end else if (beats_m[ch] + 1 == ML) begin
          e_eop = 1; e_err[2] = 1; open_m[ch] = 0; drop_m[ch] = 1;
        end else begin
          beats_m[ch]++;
        end
      end else if (s) begin
        e_valid = 1; e_sop = 1; e_eop = e;
        drop_m[ch] = 0; open_m[ch] = !e; beats_m[ch] = 1;
      end else if (drop_m[ch]) begin
        if (e) drop_m[ch] = 0;
      end else begin
        e_err = 4'b0010; e_valid = !DROP;
      end
    end
    if (e_err != 0 && cnt_m < (1 << CW) - 1) cnt_m++;
  endtask

  task automatic step(input bit rst_n, input bit v, input bit s, input bit e,
                      input int ch, input logic [DW-1:0] d);
    i_srst_n = rst_n; i_valid = v; i_sop = s; i_eop = e;
    i_ch = CHW'(ch); i_data = d;
    model(rst_n, v, s, e, ch, d);
    @(posedge clk);
    #1;
    chk("valid", 64'(o_valid), 64'(e_valid));
    chk("sop",   64'(o_sop),   64'(e_sop));
    chk("eop",   64'(o_eop),   64'(e_eop));
    chk("err",   64'(o_err),   64'(e_err));
    chk("cnt",   64'(o_errCnt), 64'(cnt_m));
    chk("ch",    64'(o_ch),    64'(e_ch));
    chk("data",  64'(o_data),  64'(e_data));
  endtask

  initial begin
    i_srst_n = 0; i_valid = 0; i_sop = 0; i_eop = 0; i_ch = 0; i_data = 0;
    #2;
    step(0, 1, 1, 0, 1, 8'hAA);
    step(0, 0, 0, 0, 0, 8'h00);
    chk("rst_out", 64'({o_valid, o_sop, o_eop, o_err, o_errCnt, o_data}), 64'd0);

    // clean 4-beat frame on ch0
    step(1, 1, 1, 0, 0, 8'h10);
    chk("t1_sop", 64'({o_valid, o_sop, o_eop}), 64'b110);
    step(1, 1, 0, 0, 0, 8'h11);
    step(1, 1, 0, 0, 0, 8'h12);
    step(1, 1, 0, 1, 0, 8'h13);
    chk("t1_eop", 64'({o_valid, o_sop, o_eop, o_err}), {57'd0, 7'b1010000});

    // orphan EOP on ch1
    step(1, 1, 0, 1, 1, 8'h20);
    chk("t2_err", 64'({o_valid, o_err, o_errCnt}), 64'({1'b0, 4'b0010, 5'd1}));

    // ch2 runs past MAX_LEN
    step(1, 1, 1, 0, 2, 8'h30);
    for (int k = 1; k <= 5; k++) begin
      step(1, 1, 0, 0, 2, 8'(8'h30 + k));
      if (k == 3) chk("t3_cut", 64'({o_valid, o_eop, o_err}), 64'({2'b11, 4'b0100}));
      if (k > 3)  chk("t3_drop", 64'({o_valid, o_err}), 64'd0);
    end
    step(1, 1, 0, 1, 2, 8'h3F);
    chk("t3_eopdrop", 64'({o_valid, o_err}), 64'd0);
    step(1, 1, 1, 1, 2, 8'h3E);
    chk("t3_idle", 64'({o_valid, o_sop, o_eop}), 64'b111);

    // interleaved frames with one spurious SOP
    step(1, 1, 1, 0, 0, 8'h40);
    step(1, 1, 1, 0, 2, 8'h41);
    step(1, 1, 1, 0, 0, 8'h42);
    chk("t4_spur", 64'({o_valid, o_sop, o_err}), 64'({2'b10, 4'b0001}));
    step(1, 1, 0, 1, 2, 8'h43);
    step(1, 1, 0, 1, 0, 8'h44);

    // out-of-range channel leaves trackers alone
    step(1, 1, 1, 0, 1, 8'h50);
    step(1, 1, 0, 1, 3, 8'h51);
    chk("t5_badch", 64'({o_valid, o_err}), 64'({1'b0, 4'b1000}));
    step(1, 1, 0, 1, 1, 8'h52);
    chk("t5_ch1", 64'({o_valid, o_eop, o_err}), 64'({2'b11, 4'b0000}));

    // reset abandons an open frame
    step(1, 1, 1, 0, 1, 8'h60);
    step(0, 1, 0, 0, 1, 8'h61);
    chk("t6_rst", 64'({o_valid, o_errCnt, o_ch, o_data}), 64'd0);
    step(1, 1, 0, 1, 1, 8'h62);
    chk("t6_orph", 64'({o_valid, o_err, o_errCnt}), 64'({1'b0, 4'b0010, 5'd1}));

    // saturate the error counter
    for (int k = 0; k < (1 << CW) + 1; k++) step(1, 1, 0, 0, 3, 8'(k));
    chk("sat", 64'(o_errCnt), 64'd31);
    step(1, 1, 0, 1, 3, 8'h70);
    chk("sat_hold", 64'(o_errCnt), 64'd31);

    step(0, 0, 0, 0, 0, 8'h00);
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 8,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           int'($urandom_range(0, 3)), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
